// File: rtl/multdiv_unit.sv
// Sequential signed 32-bit multiply/divide unit for the execute stage.
// One 33-bit add/sub datapath is shared by a shift-add multiplier and a
// restoring divider. Both work on operand magnitudes; the sign is applied
// when the result is registered. Fixed latency of 33 cycles from start to RDY.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_next;
    logic [5:0]         iter;
    logic [WIDTH-1:0]   hi;          // accumulator (MUL) / partial remainder (DIV)
    logic [WIDTH-1:0]   lo;          // multiplier (MUL) / dividend-quotient (DIV)
    logic [WIDTH:0]     mag_op;      // |A| for MUL, |B| for DIV
    logic               neg;         // result sign, A31 ^ B31
    logic               op_div;
    logic               div_zero;
    logic               div_ovf;

    logic               start;
    logic [WIDTH:0]     mag_a, mag_b;
    logic               alu_sub;
    logic [WIDTH:0]     alu_a, alu_b, alu_out;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   done_result;
    logic               done_exc;

    // Exactly one start line high; both high together is ignored.
    assign start = ctrl_MULT ^ ctrl_DIV;

    // Magnitudes held in 33 bits so that |-2^31| = 2^31 is representable.
    assign mag_a = data_operandA[WIDTH-1]
                 ? {(WIDTH+1){1'b0}} - {data_operandA[WIDTH-1], data_operandA}
                 : {1'b0, data_operandA};
    assign mag_b = data_operandB[WIDTH-1]
                 ? {(WIDTH+1){1'b0}} - {data_operandB[WIDTH-1], data_operandB}
                 : {1'b0, data_operandB};

    // Busy covers the iterations and the DONE cycle; it decodes registered state only.
    assign data_busy = (state != IDLE);

    // State register; reset wins over any start request.
    // NOTE: sequential state is updated with <= so every flop samples the pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: a start always (re)launches, otherwise count through to DONE.
    // NOTE: state_next is defaulted first so no path through this block infers a latch.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                MUL, DIV: if (iter == 6'd31) state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = state;
            endcase
        end
    end

    // Shared adder: add the multiplicand in MUL, subtract the divisor in DIV.
    always_comb begin
        alu_sub = (state == DIV);
        alu_a   = alu_sub ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        alu_b   = alu_sub ? mag_op : (lo[0] ? mag_op : {(WIDTH+1){1'b0}});
        alu_out = alu_a + (alu_b ^ {(WIDTH+1){alu_sub}}) + {{WIDTH{1'b0}}, alu_sub};
    end

    // Operand latch on start, then one shift-add or restoring-divide step per cycle.
    // NOTE: only the iteration counter is reset; datapath registers are always loaded on start before use.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iter <= '0;
        end else if (start) begin
            iter     <= '0;
            hi       <= '0;
            lo       <= ctrl_MULT ? mag_b[WIDTH-1:0] : mag_a[WIDTH-1:0];
            mag_op   <= ctrl_MULT ? mag_a : mag_b;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            op_div   <= ctrl_DIV;
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
        end else if (state == MUL) begin
            iter <= iter + 6'd1;
            hi   <= alu_out[WIDTH:1];
            lo   <= {alu_out[0], lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            iter <= iter + 6'd1;
            // A borrow means the trial subtraction failed: restore the shifted remainder.
            hi   <= alu_out[WIDTH] ? alu_a[WIDTH-1:0] : alu_out[WIDTH-1:0];
            lo   <= {lo[WIDTH-2:0], ~alu_out[WIDTH]};
        end
    end

    // Final sign application and exception rules, consumed in the DONE cycle.
    always_comb begin
        prod_mag    = {hi, lo};
        prod        = neg ? {(2*WIDTH){1'b0}} - prod_mag : prod_mag;
        quot        = neg ? {WIDTH{1'b0}} - lo : lo;
        done_result = prod[WIDTH-1:0];
        done_exc    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
        if (op_div) begin
            if (div_zero) begin
                done_result = '0;
                done_exc    = 1'b1;
            end else if (div_ovf) begin
                done_result = MIN_NEG;
                done_exc    = 1'b1;
            end else begin
                done_result = quot;
                done_exc    = 1'b0;
            end
        end
    end

    // Output registers: capture in DONE unless a new start aborts it; RDY is a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == DONE && !start) begin
                data_result    <= done_result;
                data_exception <= done_exc;
                data_resultRDY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, hand-written
// restart/reset/simultaneous-start sequences, and a random back-to-back
// regression against a native-arithmetic reference model via a scoreboard.
module tb_multdiv_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    typedef struct packed {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[16];

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model from native signed arithmetic.
    task automatic model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint      p;
        logic [63:0] pv;
        int          sa;
        int          sb_i;
        sa   = a;
        sb_i = b;
        if (!is_div) begin
            p   = longint'(sa) * longint'(sb_i);
            pv  = p;
            res = pv[31:0];
            exc = !((pv[63:31] == '0) || (pv[63:31] == '1));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            res = sa / sb_i;
            exc = 1'b0;
        end
    endtask

    // Called just after a negedge: start is sampled at the next rising edge,
    // and the task returns at the negedge following that edge.
    task automatic start_pulse(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Counts negedges from the start until RDY; busy is counted on the way.
    task automatic wait_rdy(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clock);
            if (data_resultRDY) begin
                lat = k;
                break;
            end
            if (data_busy) busy_cnt++;
        end
    endtask

    task automatic finish_op(input string name);
        int   lat;
        int   busy_cnt;
        exp_t e;
        wait_rdy(lat, busy_cnt);
        check({name, "_latency"}, lat, 33);
        check({name, "_busy_cycles"}, busy_cnt, 33);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_result"}, data_result, e.res);
            check({name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] s;
        s = $urandom_range(0, 20);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return s;
            4:       return -s;
            5:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          quiet;
        logic [31:0] r_res;
        logic        r_exc;
        logic        r_div;
        logic [31:0] r_a;
        logic [31:0] r_b;
        exp_t        e;

        vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
        vecs[1]  = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1};
        vecs[6]  = '{1'b0, 32'd0,          32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{1'b1, 32'd100,        32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0};
        vecs[9]  = '{1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
        vecs[12] = '{1'b1, 32'd7,          32'd7,         32'h0000_0001, 1'b0};
        vecs[13] = '{1'b1, 32'd3,          32'd5,         32'h0000_0000, 1'b0};
        vecs[14] = '{1'b1, 32'hFFFF_FFF7,  32'hFFFF_FFFD, 32'h0000_0003, 1'b0};
        vecs[15] = '{1'b1, 32'd0,          32'd0,         32'h0000_0000, 1'b1};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, data_busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed table, issued back to back.
        for (int i = 0; i < 16; i++) begin
            sb.push_back('{vecs[i].res, vecs[i].exc});
            start_pulse(vecs[i].is_div, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i));
            if (i == 0) begin
                @(negedge clock);
                check("rdy_single_cycle", {31'd0, data_resultRDY}, 32'd0);
                check("result_holds", data_result, 32'hFFFF_FFD6);
            end
        end

        // Restart: DIV 1000/3 aborted by MULT 3x4 ten cycles later.
        start_pulse(1'b1, 32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        sb.push_back('{32'd12, 1'b0});
        start_pulse(1'b0, 32'd3, 32'd4);
        finish_op("restart");
        check("restart_queue_empty", sb.size(), 0);

        // Both start lines high: no operation.
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        quiet     = 0;
        for (int k = 0; k < 40; k++) begin
            if (data_busy || data_resultRDY) quiet++;
            @(negedge clock);
        end
        check("dual_start_ignored", quiet, 0);
        check("dual_start_result_kept", data_result, 32'd12);

        // Reset during a multiply, with a start asserted alongside it.
        start_pulse(1'b0, 32'h1234, 32'h5678);
        repeat (19) @(negedge clock);
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(negedge clock);
        check("midreset_result", data_result, 32'd0);
        check("midreset_exception", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midreset_busy", {31'd0, data_busy}, 32'd0);
        reset_n   = 1'b1;
        ctrl_MULT = 1'b0;
        quiet     = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (data_busy || data_resultRDY) quiet++;
        end
        check("post_reset_quiet", quiet, 0);
        sb.push_back('{32'd9, 1'b0});
        start_pulse(1'b0, 32'd3, 32'd3);
        finish_op("after_reset");

        // Random back-to-back regression against the model.
        for (int i = 0; i < 600; i++) begin
            r_div = $urandom_range(0, 1);
            r_a   = pick_operand();
            r_b   = pick_operand();
            model(r_div, r_a, r_b, r_res, r_exc);
            e.res = r_res;
            e.exc = r_exc;
            sb.push_back(e);
            start_pulse(r_div, r_a, r_b);
            finish_op($sformatf("rand%0d_%s_%08h_%08h", i, r_div ? "div" : "mul", r_a, r_b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
